// File: rtl/alu_seq_if.sv
// Control-unit handshake and operand/result bus for the sequential ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             Start;
    logic             Abort;
    logic [4:0]       OpCode;
    logic [WIDTH-1:0] Op1;
    logic [WIDTH-1:0] Op2;
    logic             CarryIn;
    logic             Ready;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [3:0]       Flags;

    modport master (
        output Start,
        output Abort,
        output OpCode,
        output Op1,
        output Op2,
        output CarryIn,
        input  Ready,
        input  Done,
        input  Result,
        input  Flags
    );

    modport slave (
        input  Start,
        input  Abort,
        input  OpCode,
        input  Op1,
        input  Op2,
        input  CarryIn,
        output Ready,
        output Done,
        output Result,
        output Flags
    );

endinterface

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: one-clock arithmetic/logic, bit-serial shifts,
// shift-add unsigned multiply, with Start/Ready/Done handshake and Abort.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic      Clock,
    input  logic      nReset,
    alu_seq_if.slave  bus
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned CW  = SHW + 1;

    localparam logic [4:0] OP_PASS = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_NOT  = 5'd5;
    localparam logic [4:0] OP_LSL  = 5'd6;
    localparam logic [4:0] OP_LSR  = 5'd7;
    localparam logic [4:0] OP_ASR  = 5'd8;
    localparam logic [4:0] OP_MUL  = 5'd9;
    localparam logic [4:0] OP_ADC  = 5'd10;
    localparam logic [4:0] OP_SBC  = 5'd11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [4:0]           op_q;
    logic [WIDTH-1:0]     sh_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     result_q;
    logic [3:0]           flags_q;
    logic                 done_q;

    logic                 sub_c;
    logic                 cin_c;
    logic [WIDTH-1:0]     opb_c;
    logic [WIDTH:0]       sum_c;
    logic [WIDTH-1:0]     res_c;
    logic                 carry_c;
    logic                 ovf_c;
    logic [3:0]           flags_c;
    logic                 is_shift_c;
    logic [SHW-1:0]       shamt_c;
    logic [WIDTH-1:0]     sh_next_c;
    logic                 sh_out_c;
    logic [2*WIDTH-1:0]   acc_next_c;

    assign bus.Ready  = (state_q == S_IDLE);
    assign bus.Done   = done_q;
    assign bus.Result = result_q;
    assign bus.Flags  = flags_q;

    assign shamt_c    = bus.Op2[SHW-1:0];
    assign is_shift_c = (bus.OpCode == OP_LSL) || (bus.OpCode == OP_LSR) ||
                        (bus.OpCode == OP_ASR);

    // Single-cycle result; subtraction is A + ~B + carry so C comes out as NOT borrow.
    always_comb begin
        sub_c   = (bus.OpCode == OP_SUB) || (bus.OpCode == OP_SBC);
        opb_c   = sub_c ? ~bus.Op2 : bus.Op2;
        cin_c   = 1'b0;
        if (bus.OpCode == OP_SUB) begin
            cin_c = 1'b1;
        end else if ((bus.OpCode == OP_ADC) || (bus.OpCode == OP_SBC)) begin
            cin_c = bus.CarryIn;
        end
        sum_c   = {1'b0, bus.Op1} + {1'b0, opb_c} + (WIDTH+1)'(cin_c);
        res_c   = bus.Op1;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (bus.OpCode)
            OP_PASS: res_c = bus.Op1;
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                res_c   = sum_c[WIDTH-1:0];
                carry_c = sum_c[WIDTH];
                ovf_c   = (bus.Op1[MSB] == opb_c[MSB]) && (sum_c[MSB] != bus.Op1[MSB]);
            end
            OP_AND:  res_c = bus.Op1 & bus.Op2;
            OP_OR:   res_c = bus.Op1 | bus.Op2;
            OP_NOT:  res_c = ~bus.Op1;
            default: res_c = bus.Op1;
        endcase
        flags_c = {res_c[MSB], (res_c == '0), carry_c, ovf_c};
    end

    // One-bit shift step on the latched operand.
    always_comb begin
        case (op_q)
            OP_LSL: begin
                sh_next_c = {sh_q[WIDTH-2:0], 1'b0};
                sh_out_c  = sh_q[MSB];
            end
            OP_LSR: begin
                sh_next_c = {1'b0, sh_q[WIDTH-1:1]};
                sh_out_c  = sh_q[0];
            end
            default: begin
                sh_next_c = {sh_q[MSB], sh_q[WIDTH-1:1]};
                sh_out_c  = sh_q[0];
            end
        endcase
    end

    assign acc_next_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sh_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            flags_q  <= 4'b0100;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Abort in the same cycle suppresses the launch.
                    if (bus.Start && !bus.Abort) begin
                        if (is_shift_c && (shamt_c != '0)) begin
                            op_q    <= bus.OpCode;
                            sh_q    <= bus.Op1;
                            cnt_q   <= CW'(shamt_c);
                            state_q <= S_SHIFT;
                        end else if (bus.OpCode == OP_MUL) begin
                            acc_q    <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, bus.Op1};
                            mplier_q <= bus.Op2;
                            cnt_q    <= CW'(WIDTH);
                            state_q  <= S_MUL;
                        end else begin
                            result_q <= res_c;
                            flags_q  <= flags_c;
                            done_q   <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (bus.Abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        sh_q  <= sh_next_c;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            result_q <= sh_next_c;
                            flags_q  <= {sh_next_c[MSB], (sh_next_c == '0), sh_out_c, 1'b0};
                            done_q   <= 1'b1;
                            state_q  <= S_IDLE;
                        end
                    end
                end
                S_MUL: begin
                    if (bus.Abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q    <= acc_next_c;
                        mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                        mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                        cnt_q    <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            result_q <= acc_next_c[WIDTH-1:0];
                            flags_q  <= {acc_next_c[MSB], (acc_next_c[WIDTH-1:0] == '0),
                                         (acc_next_c[2*WIDTH-1:WIDTH] != '0), 1'b0};
                            done_q   <= 1'b1;
                            state_q  <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, abort/reset cases and
// randomized operations against an arithmetic reference model.
module tb_alu_seq;

    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [15:0] m_res;
    logic [3:0]  m_flg;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .Clock  (clk),
        .nReset (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the opcode definitions.
    task automatic model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, output logic [15:0] r, output logic [3:0] f,
                         output int busy);
        int n, ua, ub, sa, sb, u, s, extra;
        logic c, v;
        logic [31:0] prod;
        n  = int'(b[3:0]);
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = 1'b0; v = 1'b0; busy = 0; r = a;
        case (op)
            5'd1, 5'd10: begin
                extra = (op == 5'd10) ? int'(cin) : 0;
                u = ua + ub + extra;
                s = sa + sb + extra;
                r = 16'(u);
                c = (u > 65535);
                v = (s > 32767) || (s < -32768);
            end
            5'd2, 5'd11: begin
                extra = (op == 5'd11) ? int'(!cin) : 0;
                u = ua - ub - extra;
                s = sa - sb - extra;
                r = 16'(u);
                c = (u >= 0);
                v = (s > 32767) || (s < -32768);
            end
            5'd3: r = a & b;
            5'd4: r = a | b;
            5'd5: r = ~a;
            5'd6: begin
                r = a << n;
                if (n > 0) c = a[16-n];
                busy = n;
            end
            5'd7: begin
                r = a >> n;
                if (n > 0) c = a[n-1];
                busy = n;
            end
            5'd8: begin
                r = 16'($signed(a) >>> n);
                if (n > 0) c = a[n-1];
                busy = n;
            end
            5'd9: begin
                prod = 32'(a) * 32'(b);
                r    = prod[15:0];
                c    = (prod[31:16] != 16'h0);
                busy = 16;
            end
            default: r = a;
        endcase
        f = {r[15], (r == 16'h0), c, v};
    endtask

    // Launch one op at the current negedge and wait (bounded) for Done.
    task automatic do_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, output logic [15:0] res, output logic [3:0] flg,
                         output int busy, output bit got);
        bus.OpCode  = op;
        bus.Op1     = a;
        bus.Op2     = b;
        bus.CarryIn = cin;
        bus.Start   = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        busy = 0;
        got  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (bus.Ready === 1'b0) busy++;
        end
        res = bus.Result;
        flg = bus.Flags;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.Result !== 16'h0 || bus.Flags !== 4'b0100 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got res=%h flags=%b done=%b want 0000/0100/0", bus.Result, bus.Flags, bus.Done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.Ready !== 1'b1 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got ready=%b done=%b want 1/0", bus.Ready, bus.Done);
        end
        m_res = 16'h0;
        m_flg = 4'b0100;
    endtask

    // Directed vectors issued back-to-back on each Done cycle.
    task automatic test_directed();
        logic [4:0]  ops  [6] = '{5'd1, 5'd2, 5'd10, 5'd9, 5'd9, 5'd6};
        logic [15:0] op1s [6] = '{16'h7FFF, 16'h0005, 16'hFFFF, 16'h0100, 16'h0003, 16'h1234};
        logic [15:0] op2s [6] = '{16'h0001, 16'h0005, 16'h0000, 16'h0101, 16'h0005, 16'h0010};
        logic        cins [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] eres [6] = '{16'h8000, 16'h0000, 16'h0000, 16'h0100, 16'h000F, 16'h1234};
        logic [3:0]  eflg [6] = '{4'b1001, 4'b0110, 4'b0110, 4'b0010, 4'b0000, 4'b0000};
        int          ebsy [6] = '{0, 0, 0, 16, 16, 0};
        logic [15:0] res;
        logic [3:0]  flg;
        int          busy;
        bit          got;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], op1s[i], op2s[i], cins[i], res, flg, busy, got);
            checks++;
            if (!got || res !== eres[i] || flg !== eflg[i] || busy != ebsy[i]) begin
                errors++;
                $display("FAIL directed_%0d: got done=%0d res=%h flags=%b busy=%0d want res=%h flags=%b busy=%0d",
                         i, got, res, flg, busy, eres[i], eflg[i], ebsy[i]);
            end
        end
        m_res = 16'h1234;
        m_flg = 4'b0000;
    endtask

    task automatic test_shift_ignore();
        int  cyc;
        bit  got;
        bus.OpCode = 5'd8; bus.Op1 = 16'h8004; bus.Op2 = 16'h0003; bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.Ready !== 1'b0) begin
            errors++;
            $display("FAIL shift_busy: got ready=%b want 0", bus.Ready);
        end
        bus.OpCode = 5'd1; bus.Op1 = 16'h0001; bus.Op2 = 16'h0001; bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        cyc = 1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.Done === 1'b1) begin
                got = 1'b1;
                break;
            end
            checks++;
            if (bus.Result !== m_res) begin
                errors++;
                $display("FAIL shift_hold: got res=%h want %h", bus.Result, m_res);
            end
        end
        checks++;
        if (!got || cyc != 4 || bus.Result !== 16'hF000 || bus.Flags !== 4'b1010) begin
            errors++;
            $display("FAIL asr_result: got done=%0d cyc=%0d res=%h flags=%b want cyc=4 res=f000 flags=1010",
                     got, cyc, bus.Result, bus.Flags);
        end
        @(negedge clk);
        checks++;
        if (bus.Done !== 1'b0 || bus.Result !== 16'hF000 || bus.Ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_start_ignored: got done=%b res=%h ready=%b want 0/f000/1", bus.Done, bus.Result, bus.Ready);
        end
        m_res = 16'hF000;
        m_flg = 4'b1010;
    endtask

    task automatic test_abort();
        logic [15:0] res;
        logic [3:0]  flg;
        int          busy, dones;
        bit          got;
        do_op(5'd1, 16'h1234, 16'h1111, 1'b0, res, flg, busy, got);
        checks++;
        if (!got || res !== 16'h2345 || flg !== 4'b0000) begin
            errors++;
            $display("FAIL abort_setup: got res=%h flags=%b want 2345/0000", res, flg);
        end
        bus.OpCode = 5'd9; bus.Op1 = 16'h00FF; bus.Op2 = 16'h0013; bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        repeat (5) @(negedge clk);
        bus.Abort = 1'b1;
        @(posedge clk);
        #1 bus.Abort = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.Ready !== 1'b1 || bus.Done !== 1'b0 || bus.Result !== 16'h2345 || bus.Flags !== 4'b0000) begin
            errors++;
            $display("FAIL abort_mul: got ready=%b done=%b res=%h flags=%b want 1/0/2345/0000",
                     bus.Ready, bus.Done, bus.Result, bus.Flags);
        end
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.Done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d dones want 0", dones);
        end
        bus.OpCode = 5'd4; bus.Op1 = 16'h00F0; bus.Op2 = 16'h000F; bus.Start = 1'b1; bus.Abort = 1'b1;
        @(posedge clk);
        #1 begin bus.Start = 1'b0; bus.Abort = 1'b0; end
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.Done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || bus.Result !== 16'h2345) begin
            errors++;
            $display("FAIL idle_abort_wins: got dones=%0d res=%h want 0/2345", dones, bus.Result);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] res;
        logic [3:0]  flg;
        int          busy;
        bit          got;
        do_op(5'd1, 16'hFFFF, 16'h0002, 1'b0, res, flg, busy, got);
        checks++;
        if (!got || res !== 16'h0001 || flg !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_setup: got res=%h flags=%b want 0001/0010", res, flg);
        end
        bus.OpCode = 5'd9; bus.Op1 = 16'h0123; bus.Op2 = 16'h0456; bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.Result !== 16'h0 || bus.Flags !== 4'b0100 || bus.Done !== 1'b0 || bus.Ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_op: got res=%h flags=%b done=%b ready=%b want 0000/0100/0/1",
                     bus.Result, bus.Flags, bus.Done, bus.Ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (bus.Done !== 1'b0 || bus.Result !== 16'h0) begin
                errors++;
                $display("FAIL reset_discard: got done=%b res=%h want 0/0000", bus.Done, bus.Result);
            end
        end
        m_res = 16'h0;
        m_flg = 4'b0100;
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [15:0] a, b, er, res;
        logic [3:0]  ef, flg;
        logic        cin;
        int          eb, busy;
        bit          got;
        for (int i = 0; i < 250; i++) begin
            op  = 5'($urandom_range(0, 31));
            if ((i % 3) == 0) op = 5'($urandom_range(0, 11));
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            model(op, a, b, cin, er, ef, eb);
            do_op(op, a, b, cin, res, flg, busy, got);
            checks++;
            if (!got || res !== er || flg !== ef || busy != eb) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h cin=%b: got done=%0d res=%h flags=%b busy=%0d want res=%h flags=%b busy=%0d",
                         i, op, a, b, cin, got, res, flg, busy, er, ef, eb);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_res  = 16'h0;
        m_flg  = 4'b0100;
        rst_n       = 1'b0;
        bus.Start   = 1'b0;
        bus.Abort   = 1'b0;
        bus.OpCode  = 5'd0;
        bus.Op1     = 16'h0;
        bus.Op2     = 16'h0;
        bus.CarryIn = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_directed();
        test_shift_ignore();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
